instruction_fetch: RTL and testbench

Instruction fetch stage of the MIPS CPU, sitting directly upstream of the `control` decoder. It owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and buffers up to two fetched words. It presents them in order to the decode/control stage as `instrucao` with a valid/ready handshake. Branch and jump redirects flush the buffer and restart fetch, and a stale in-flight memory response is discarded.

---
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers up to two {pc, word} entries and hands them to decode in order.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instrucao,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

  localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'd3;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] pend_reg;
  logic [31:0] pc_q   [2];
  logic [31:0] word_q [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  occ_reg;
  logic [1:0]  occ_next;
  logic [31:0] target;
  logic        push;
  logic        pop;

  assign target = redirect_pc & ~32'd3;
  // A redirect swallows both the same-cycle ack and the same-cycle pop.
  assign push   = (state_reg == FETCH) && mem_ack && !redirect;
  assign pop    = (occ_reg != 2'd0) && instr_ready && !redirect;

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  assign mem_req     = (state_reg == FETCH) || (state_reg == KILL);
  assign mem_addr    = addr_reg;
  assign instr_valid = (occ_reg != 2'd0);
  assign instrucao   = word_q[rd_ptr_reg];
  assign instr_pc    = pc_q[rd_ptr_reg];

  // addr_reg is the address on the bus; pend_reg holds the redirect target
  // while a stale request drains in KILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= RESET_ADDR;
      pend_reg  <= RESET_ADDR;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          if (redirect) addr_reg <= target;
        end
        FETCH: begin
          if (redirect) begin
            if (mem_ack) begin
              addr_reg  <= target;
              state_reg <= FETCH;
            end else begin
              pend_reg  <= target;
              state_reg <= KILL;
            end
          end else if (mem_ack) begin
            addr_reg  <= addr_reg + 32'd4;
            state_reg <= (occ_next == 2'd2) ? HOLD : FETCH;
          end
        end
        HOLD: begin
          if (redirect) begin
            addr_reg  <= target;
            state_reg <= FETCH;
          end else if (occ_reg != 2'd2) begin
            state_reg <= FETCH;
          end
        end
        KILL: begin
          if (mem_ack) begin
            addr_reg  <= redirect ? target : pend_reg;
            state_reg <= FETCH;
          end else if (redirect) begin
            pend_reg <= target;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg    <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else if (redirect) begin
      occ_reg    <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      occ_reg    <= occ_next;
      wr_ptr_reg <= wr_ptr_reg ^ push;
      rd_ptr_reg <= rd_ptr_reg ^ pop;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      localparam int unsigned SLOT = gi;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_q[gi]   <= 32'd0;
          word_q[gi] <= 32'd0;
        end else if (push && (wr_ptr_reg == SLOT[0])) begin
          pc_q[gi]   <= addr_reg;
          word_q[gi] <= mem_rdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a delay-programmable memory model
// pushes expected {pc, word} on each useful ack; delivered entries are popped and compared.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instrucao;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  instruction_fetch #(.RESET_PC(32'h0000_0102)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instrucao(instrucao), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          delivered = 0;
  int          delay = 0;
  int          wcnt = 0;
  logic        spurious = 1'b0;
  logic        stale = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] exp_addr = 32'h100;
  logic [63:0] sb_q [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory responds and the scoreboard evaluates at the negedge,
  // then the task returns 1 time unit after the rising edge.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    mem_ack   = mem_req ? (wcnt >= delay) : spurious;
    mem_rdata = word_of(mem_addr);
    if (mem_req && prev_wait) check("addr_stable", mem_addr, prev_addr);
    if (instr_valid && instr_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        check("unexpected_instr", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("instr_pc", instr_pc, e[63:32]);
        check("instrucao", instrucao, e[31:0]);
        delivered++;
      end
    end
    if (mem_req && mem_ack) begin
      if (stale || redirect) begin
        stale = 1'b0;
      end else begin
        check("fetch_addr", mem_addr, exp_addr);
        sb_q.push_back({exp_addr, word_of(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
      wcnt = 0;
    end else if (mem_req) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr;
    if (redirect) begin
      sb_q.delete();
      exp_addr = redirect_pc & ~32'd3;
      if (mem_req && !mem_ack) stale = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    cycle();
    redirect    = 1'b0;
  endtask

  initial begin
    logic [63:0] head;
    logic [31:0] old_a;
    int          d0;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h100);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instrucao", instrucao, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Sequential fetch, zero-wait memory
    rst_n = 1'b1;
    check("idle_no_req", {31'd0, mem_req}, 32'd0);
    cycle();
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h100);
    cycles(8);
    check("throughput", delivered, 32'd7);
    check("steady_valid", {31'd0, instr_valid}, 32'd1);
    $display("seq: delivered %0d, mem_addr %h", delivered, mem_addr);

    // Backpressure fills the buffer; spurious acks in HOLD must be ignored
    instr_ready = 1'b0;
    cycle();
    head = sb_q[0];
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("full_no_req", {31'd0, mem_req}, 32'd0);
      check("held_pc", instr_pc, head[63:32]);
      check("held_word", instrucao, head[31:0]);
    end
    check("full_depth", sb_q.size(), 32'd2);
    spurious = 1'b0;
    instr_ready = 1'b1;
    cycle();
    check("bubble", {31'd0, mem_req}, 32'd0);
    cycle();
    check("resume_req", {31'd0, mem_req}, 32'd1);
    check("resume_addr", mem_addr, exp_addr);
    $display("backpressure: head %h, resume at %h", head[63:32], mem_addr);

    // Redirect while a slow request is outstanding
    delay = 3;
    cycles(2);
    old_a = mem_addr;
    do_redirect(32'h0000_2002);
    check("kill_addr_kept", mem_addr, old_a);
    check("kill_req", {31'd0, mem_req}, 32'd1);
    check("kill_flush", {31'd0, instr_valid}, 32'd0);
    cycle();
    check("after_stale_addr", mem_addr, 32'h2000);
    cycles(10);
    $display("redirect outstanding: old %h, now %h", old_a, mem_addr);

    // Redirect coinciding with an ack and a pop
    delay = 0;
    cycles(4);
    check("pre_same_valid", {31'd0, instr_valid}, 32'd1);
    do_redirect(32'h0000_3000);
    check("same_valid", {31'd0, instr_valid}, 32'd0);
    check("same_addr", mem_addr, 32'h3000);
    cycles(4);
    $display("redirect same-cycle: delivered %0d", delivered);

    // PC wrap
    do_redirect(32'hFFFF_FFFE);
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_addr1", mem_addr, 32'h0000_0000);
    cycles(3);
    $display("wrap: mem_addr %h", mem_addr);

    // Redirect while the buffer is full
    instr_ready = 1'b0;
    cycles(3);
    check("hold_no_req", {31'd0, mem_req}, 32'd0);
    do_redirect(32'h0000_4000);
    check("hold_redir_addr", mem_addr, 32'h4000);
    check("hold_redir_req", {31'd0, mem_req}, 32'd1);
    check("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    cycles(3);
    $display("hold redirect: mem_addr %h", mem_addr);

    // Asynchronous reset mid-fetch
    delay = 3;
    instr_ready = 1'b0;
    cycles(2);
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", {31'd0, mem_req}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'h100);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_instrucao", instrucao, 32'd0);
    check("arst_instr_pc", instr_pc, 32'd0);
    sb_q.delete();
    stale = 1'b0; wcnt = 0; prev_wait = 1'b0; exp_addr = 32'h100;
    delay = 0; instr_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_no_req", {31'd0, mem_req}, 32'd0);
    d0 = delivered;
    cycle();
    check("rel_req", {31'd0, mem_req}, 32'd1);
    check("rel_addr", mem_addr, 32'h100);
    cycles(5);
    check("rel_delivered", delivered - d0, 32'd4);
    $display("async reset: restarted, delivered %0d", delivered - d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
